// File: rtl/bch_data_correct.sv
// bch_data_correct: circular store of received BCH data bits, XOR-corrected
// by the error-locator stream and emitted one cycle after each err beat.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid/in_first/in_data  received data beats (data portion, LSB first)
//   in_ready                   storage has room for a beat
//   err_valid/err_first/err_last/err  error-mask beats from the locator
//   out_valid/out_first/out_last/out_data  corrected data, 1 cycle latency
//   underflow                  sticky: err beat arrived with storage empty
//   sync_err                   sticky: first-beat markers out of alignment
//   corrected_count            (BCH_CORRECT_COUNT_EN only) per-codeword
//                              error popcount, saturating, valid on out_last
//
// Optional feature macro: BCH_CORRECT_COUNT_EN

`ifndef BCH_DATA_BITS
`define BCH_PARAMS(DATA, T) {16'(DATA), 16'(T)}
`define BCH_SANE `BCH_PARAMS(16, 3)
`define BCH_DATA_BITS(P) (int'(((P) >> 16) & 32'hffff))
`define BCH_T(P) (int'((P) & 32'hffff))
`define BCH_ERR_SZ(P) $clog2(`BCH_T(P) + 1)
`endif

module bch_data_correct #(
    parameter logic [31:0] P     = `BCH_SANE,
    parameter int          BITS  = 1,
    parameter int          DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_first,
    input  logic [BITS-1:0] in_data,
    output logic            in_ready,
    input  logic            err_first,
    input  logic            err_last,
    input  logic            err_valid,
    input  logic [BITS-1:0] err,
    output logic            out_valid,
    output logic            out_first,
    output logic            out_last,
    output logic [BITS-1:0] out_data,
    output logic            underflow,
    output logic            sync_err
`ifdef BCH_CORRECT_COUNT_EN
    ,
    output logic [`BCH_ERR_SZ(P)-1:0] corrected_count
`endif
);

    localparam int B  = `BCH_DATA_BITS(P);
    localparam int W  = B / BITS;
    localparam int N  = DEPTH * W;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    if (B % BITS != 0) begin : g_bits_chk
        $error("data bits must be a multiple of BITS");
    end
    if (DEPTH < 1) begin : g_depth_chk
        $error("DEPTH must be at least 1");
    end

    logic [BITS-1:0] mem_q [N];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   wbeat_q, wbeat_d;
    logic [BW-1:0]   rbeat_q, rbeat_d;
    logic [BW-1:0]   wbeat, rbeat;
    logic            out_valid_q, out_valid_d;
    logic            out_first_q, out_first_d;
    logic            out_last_q, out_last_d;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic            underflow_q, underflow_d;
    logic            sync_err_q, sync_err_d;
    logic            wr_en, rd_en;

    assign in_ready = (count_q < CW'(N));
    assign wr_en    = in_valid && in_ready;
    // A word written this cycle is not yet counted, so it cannot be read.
    assign rd_en    = err_valid && (count_q != '0);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wbeat_d     = wbeat_q;
        rbeat_d     = rbeat_q;
        wbeat       = wbeat_q;
        rbeat       = rbeat_q;
        out_valid_d = err_valid;
        out_first_d = err_valid && err_first;
        out_last_d  = err_valid && err_last;
        out_data_d  = out_data_q;
        underflow_d = underflow_q;
        sync_err_d  = sync_err_q;
        count_d     = count_q + CW'(wr_en) - CW'(rd_en);

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PW'(N - 1)) ? '0 : wr_ptr_q + 1'b1;
            // in_first forces this beat to be beat 0 of a codeword.
            if (in_first) begin
                wbeat = '0;
                if (wbeat_q != '0) sync_err_d = 1'b1;
            end
            wbeat_d = (wbeat == BW'(W - 1)) ? '0 : wbeat + 1'b1;
        end

        if (err_valid) begin
            if (err_first) begin
                rbeat = '0;
                if (rbeat_q != '0) sync_err_d = 1'b1;
            end
            rbeat_d = (rbeat == BW'(W - 1)) ? '0 : rbeat + 1'b1;
            if (rd_en) begin
                rd_ptr_d   = (rd_ptr_q == PW'(N - 1)) ? '0 : rd_ptr_q + 1'b1;
                out_data_d = mem_q[rd_ptr_q] ^ err;
            end else begin
                // Nothing stored: pass the mask through, pointers hold.
                out_data_d  = err;
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wbeat_q     <= '0;
            rbeat_q     <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wbeat_q     <= wbeat_d;
            rbeat_q     <= rbeat_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Storage contents are don't-care after reset; no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign underflow = underflow_q;
    assign sync_err  = sync_err_q;

`ifdef BCH_CORRECT_COUNT_EN
    localparam int ESZ  = `BCH_ERR_SZ(P);
    localparam int EMAX = (1 << ESZ) - 1;

    logic [ESZ-1:0] acc_q, acc_d;
    int             acc_sum;

    // Running popcount restarts on err_first; holds the final total
    // while the codeword's last beat is on the output.
    always_comb begin
        acc_d   = acc_q;
        acc_sum = 0;
        if (err_valid) begin
            acc_sum = (err_first ? 0 : int'(acc_q)) + $countones(err);
            if (acc_sum > EMAX) acc_sum = EMAX;
            acc_d = ESZ'(acc_sum);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign corrected_count = acc_q;
`endif

endmodule

// File: tb/tb_bch_data_correct.sv
// tb_bch_data_correct: randomized scoreboard bench for bch_data_correct.
// Reference model is a plain queue of stored words plus beat positions.

`ifndef BCH_DATA_BITS
`define BCH_PARAMS(DATA, T) {16'(DATA), 16'(T)}
`define BCH_SANE `BCH_PARAMS(16, 3)
`define BCH_DATA_BITS(P) (int'(((P) >> 16) & 32'hffff))
`define BCH_T(P) (int'((P) & 32'hffff))
`define BCH_ERR_SZ(P) $clog2(`BCH_T(P) + 1)
`endif

module tb_bch_data_correct;

    localparam int BITS  = 1;
    localparam int DEPTH = 2;
    localparam int B     = `BCH_DATA_BITS(`BCH_SANE);
    localparam int W     = B / BITS;
    localparam int N     = DEPTH * W;
    localparam int ESZ   = `BCH_ERR_SZ(`BCH_SANE);
    localparam int CMAX  = (1 << ESZ) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0, in_first = 1'b0;
    logic [BITS-1:0] in_data = '0;
    logic            in_ready;
    logic            err_first = 1'b0, err_last = 1'b0, err_valid = 1'b0;
    logic [BITS-1:0] err = '0;
    logic            out_valid, out_first, out_last;
    logic [BITS-1:0] out_data;
    logic            underflow, sync_err;
`ifdef BCH_CORRECT_COUNT_EN
    logic [ESZ-1:0]  corrected_count;
`endif

    bch_data_correct #(
        .P(`BCH_SANE), .BITS(BITS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_first(in_first),
        .in_data(in_data), .in_ready(in_ready),
        .err_first(err_first), .err_last(err_last),
        .err_valid(err_valid), .err(err),
        .out_valid(out_valid), .out_first(out_first),
        .out_last(out_last), .out_data(out_data),
        .underflow(underflow), .sync_err(sync_err)
`ifdef BCH_CORRECT_COUNT_EN
        , .corrected_count(corrected_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BITS-1:0] d;
        bit              f;
        bit              l;
        int              cyc;
        int              cnt;
    } exp_t;

    exp_t            expq[$];
    logic [BITS-1:0] mq[$];
    bit              muf, msync;
    int              wb, rb, acc;
    int              cyc = 0;
    int              checks = 0, errors = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents data.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_spurious: out_valid with nothing expected (cycle %0d)", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_first", out_first, e.f);
                    chk("out_last", out_last, e.l);
                    chk("latency", cyc, e.cyc + 1);
`ifdef BCH_CORRECT_COUNT_EN
                    if (e.l) chk("corrected_count", corrected_count, e.cnt);
`endif
                end
            end else if (expq.size() > 0 && expq[0].cyc + 1 <= cyc) begin
                e = expq.pop_front();
                checks++;
                errors++;
                $display("FAIL out_missing: no out_valid, expected from cycle %0d (cycle %0d)",
                         e.cyc, cyc);
            end
        end
    end

    // One cycle of stimulus; the model advances by the spec rules.
    task automatic step(bit iv, bit ifs, logic [BITS-1:0] id,
                        bit ev, bit ef, bit el, logic [BITS-1:0] e);
        bit   can_wr;
        int   beat;
        exp_t x;
        @(negedge clk);
        chk("in_ready", in_ready, mq.size() < N);
        chk("underflow", underflow, muf);
        chk("sync_err", sync_err, msync);
        in_valid  = iv;
        in_first  = ifs;
        in_data   = id;
        err_valid = ev;
        err_first = ef;
        err_last  = el;
        err       = e;
        can_wr = mq.size() < N;
        if (ev) begin
            if (ef && rb != 0) msync = 1;
            beat = ef ? 0 : rb;
            rb = (beat + 1) % W;
            if (mq.size() > 0) begin
                x.d = mq.pop_front() ^ e;
            end else begin
                x.d = e;
                muf = 1;
            end
            acc = (ef ? 0 : acc) + $countones(e);
            if (acc > CMAX) acc = CMAX;
            x.cnt = acc;
            x.f = ef;
            x.l = el;
            x.cyc = cyc;
            expq.push_back(x);
        end
        if (iv && can_wr) begin
            if (ifs && wb != 0) msync = 1;
            beat = ifs ? 0 : wb;
            wb = (beat + 1) % W;
            mq.push_back(id);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic do_reset(bit check);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 0; in_first = 0; in_data = '0;
        err_valid = 0; err_first = 0; err_last = 0; err = '0;
        mq.delete();
        expq.delete();
        muf = 0; msync = 0; wb = 0; rb = 0; acc = 0;
        @(negedge clk);
        if (check) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_first", out_first, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_underflow", underflow, 0);
            chk("rst_sync_err", sync_err, 0);
            chk("rst_in_ready", in_ready, 1);
        end
        reset = 1'b0;
    endtask

    task automatic write_cw();
        for (int i = 0; i < W; i++)
            step(1, i == 0, BITS'($urandom), 0, 0, 0, '0);
    endtask

    task automatic err_cw();
        for (int i = 0; i < W; i++)
            step(0, 0, '0, 1, i == 0, i == W - 1, BITS'($urandom));
    endtask

    int pos;
    int pick[$];

    initial begin
        do_reset(1);

        // Single known error at beat 5 of an all-zero codeword.
        for (int i = 0; i < W; i++) step(1, i == 0, '0, 0, 0, 0, '0);
        for (int i = 0; i < W; i++)
            step(0, 0, '0, 1, i == 0, i == W - 1, BITS'(i == 5));
        idle(2);

        // Fill past capacity: the extra beat must be dropped.
        for (int i = 0; i <= N; i++)
            step(1, (i % W) == 0, BITS'($urandom), 0, 0, 0, '0);
        idle(2);
        err_cw();
        err_cw();
        idle(2);

        // Concurrent write and correct for 3 codewords; pointers wrap.
        write_cw();
        for (int i = 0; i < 3 * W; i++)
            step(1, (i % W) == 0, BITS'($urandom),
                 1, (i % W) == 0, (i % W) == W - 1, BITS'($urandom));
        err_cw();
        idle(2);
        chk("no_underflow", underflow, 0);
        chk("no_sync_err", sync_err, 0);

        // Underflow on an empty store, sticky until reset.
        step(0, 0, '0, 1, 1, W == 1, BITS'(1));
        idle(4);
        chk("underflow_sticky", underflow, 1);
        do_reset(1);

        // Read-side misalignment at beat 3, then reset mid-codeword.
        write_cw();
        for (int i = 0; i < 3; i++)
            step(0, 0, '0, 1, i == 0, 0, BITS'($urandom));
        step(0, 0, '0, 1, 1, 0, BITS'($urandom));
        idle(2);
        chk("sync_err_read", sync_err, 1);
        step(1, 1, '1, 1, 0, 0, '0);
        do_reset(1);

        // Write-side misalignment.
        for (int i = 0; i < 3; i++) step(1, i == 0, '1, 0, 0, 0, '0);
        step(1, 1, '0, 0, 0, 0, '0);
        idle(2);
        chk("sync_err_write", sync_err, 1);
        do_reset(1);

`ifdef BCH_CORRECT_COUNT_EN
        // Three and then five error bits in one codeword.
        for (int k = 0; k < 2; k++) begin
            int nerr;
            nerr = (k == 0) ? 3 : 5;
            pick.delete();
            while (pick.size() < nerr) begin
                int p;
                p = int'($urandom_range(W - 1, 0));
                if (!(p inside {pick})) pick.push_back(p);
            end
            write_cw();
            for (int i = 0; i < W; i++)
                step(0, 0, '0, 1, i == 0, i == W - 1,
                     BITS'(i inside {pick}));
            idle(2);
        end
`endif

        // Random mixed traffic with aligned markers.
        pos = 0;
        for (int i = 0; i < 600; i++) begin
            bit iv, ev;
            iv = $urandom_range(3, 0) != 0;
            ev = ($urandom_range(2, 0) != 0) && (mq.size() > 0);
            step(iv, iv && (wb == 0), BITS'($urandom),
                 ev, ev && pos == 0, ev && pos == W - 1,
                 BITS'($urandom));
            if (ev) pos = (pos + 1) % W;
        end
        idle(3);
        chk("scoreboard_empty", expq.size(), 0);
        chk("final_underflow", underflow, 0);
        chk("final_sync_err", sync_err, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/bch_data_correct.md
BCH_DATA_CORRECT -- requirements
Module: bch_data_correct

Interface
REQ-001 Parameter P, `BCH_SANE: BCH parameter set; B = `BCH_DATA_BITS(P).
REQ-002 Parameter BITS, 1: bits per beat; B % BITS != 0 SHALL fail elaboration.
REQ-003 Parameter DEPTH, 2: codewords of data storage; DEPTH >= 1.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_data beat present.
REQ-007 in_first  input  1  beat is bit 0 of a codeword's data portion.
REQ-008 in_data  input  BITS  received data bits, pre-correction, LSB first; ECC bits never presented.
REQ-009 in_ready  output  1  storage can accept a beat.
REQ-010 err_first  input  1  first error-locator beat of a codeword.
REQ-011 err_last  input  1  last error-locator beat of a codeword.
REQ-012 err_valid  input  1  err beat present; also high with err_first and err_last.
REQ-013 err  input  BITS  error mask for the next stored beat.
REQ-014 out_valid  output  1  out_data valid.
REQ-015 out_first / out_last  output  1 each  codeword boundaries of out_data.
REQ-016 out_data  output  BITS  corrected data.
REQ-017 underflow  output  1  sticky: err_valid while storage empty.
REQ-018 sync_err  output  1  sticky: err_first not aligned to a stored codeword start.

Function
REQ-019 Storage SHALL be circular: W = B/BITS words per codeword, DEPTH*W words of BITS bits, write pointer, read pointer, occupancy count 0..DEPTH*W.
REQ-020 in_ready SHALL be 1 exactly when count < DEPTH*W.
REQ-021 in_valid && in_ready SHALL write in_data at the write pointer and advance it, wrapping from DEPTH*W-1 to 0.
REQ-022 in_valid && !in_ready SHALL drop the beat; no state change.
REQ-023 err_valid SHALL read the word at the read pointer, advance the read pointer with wrap, and register out_data = word ^ err.
REQ-024 Latency: out_valid/out_first/out_last/out_data SHALL appear exactly 1 cycle after err_valid/err_first/err_last; out_valid is low otherwise.
REQ-025 Simultaneous write and read SHALL leave count unchanged; reading a word written in the same cycle is impossible because count excludes it.
REQ-026 err_valid with count == 0 SHALL set underflow, emit out_data = err, and leave pointers unchanged.
REQ-027 A per-codeword beat counter (0..W-1) SHALL track the read side; err_first with counter != 0 SHALL set sync_err and resynchronise the counter to 0.
REQ-028 in_first with write-side beat counter != 0 SHALL set sync_err and resynchronise that counter to 0.
REQ-029 err_valid is never back-pressured; the upstream locator owns pacing.

Reset
REQ-030 Reset SHALL clear pointers, count, beat counters, out_valid, out_first, out_last, out_data, underflow, sync_err to 0; in_ready reads 1 after reset.
REQ-031 Reset mid-codeword SHALL discard all stored words; storage contents need not be cleared.
REQ-032 underflow and sync_err SHALL clear only on reset.

Configuration
REQ-033 Macro BCH_CORRECT_COUNT_EN: when defined, output corrected_count [`BCH_ERR_SZ(P)] is added, holding the popcount of all err beats of the codeword, saturating at max, valid while out_last is high.
REQ-034 Without BCH_CORRECT_COUNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification (P=`BCH_SANE, BITS=1, DEPTH=2)
REQ-035 Write B zero bits, then B err beats with err=1 at beat 5 only -> out_data=1 at beat 5 only, out_first at beat 0, out_last at beat B-1, latency 1.
REQ-036 Write 2*B beats with in_valid held high -> in_ready drops after beat 2*B; beat 2*B+1 is dropped; count stays 2*B.
REQ-037 Run a full buffer with concurrent write and err beats for 3 codewords -> pointers wrap, no data loss, underflow=0, sync_err=0.
REQ-038 err_valid with empty storage -> underflow=1 next cycle and stays 1 until reset.
REQ-039 err_first at read beat 3 -> sync_err=1; assert reset mid-codeword -> all outputs 0, in_ready=1.
REQ-040 With BCH_CORRECT_COUNT_EN defined and 3 err bits in one codeword -> corrected_count=3 with out_last.
